// File: rtl/siren_tone_generator_if.sv
// rtl/siren_tone_generator_if.sv - siren request/drive signal bundle
//
// Purpose : groups the siren request from the anti-theft FSM and the siren
//           drive/status outputs into one interface.
// Signals : siren_en     - siren request (FSM -> generator)
//           siren_out    - square-wave drive to siren (generator -> pad)
//           siren_active - generator is not idle
//           tone_hi      - high tone currently selected
//           mute         - output gate, present only with SIREN_MUTE_EN
// Modports: master - the requesting side (drives siren_en/mute)
//           slave  - the tone generator
interface siren_tone_generator_if;
    logic siren_en;
    logic siren_out;
    logic siren_active;
    logic tone_hi;
`ifdef SIREN_MUTE_EN
    logic mute;
`endif

    modport master (
        output siren_en,
`ifdef SIREN_MUTE_EN
        output mute,
`endif
        input  siren_out,
        input  siren_active,
        input  tone_hi
    );

    modport slave (
        input  siren_en,
`ifdef SIREN_MUTE_EN
        input  mute,
`endif
        output siren_out,
        output siren_active,
        output tone_hi
    );
endinterface

// File: rtl/siren_tone_generator.sv
// rtl/siren_tone_generator.sv - two-tone warble siren driver with glitch-free shutdown
//
// Purpose : turns the registered siren request into a square wave that
//           alternates between a high and a low pitch every SWAP cycles.
//           When the request drops during a high level, that level is
//           allowed to finish (DRAIN) so the output never ends in a runt pulse.
// Ports   : clk  - system clock (25 MHz)
//           rst  - asynchronous active-low reset
//           bus  - siren_tone_generator_if.slave
//                  (siren_en in; siren_out, siren_active, tone_hi out;
//                   mute in when SIREN_MUTE_EN is defined)
// Options : SIREN_MUTE_EN - adds the mute input that gates siren_out while
//           the tone engine keeps running.
module siren_tone_generator #(
    parameter int HI_HALF = 12500,
    parameter int LO_HALF = 20833,
    parameter int SWAP    = 12500000
) (
    input  logic                     clk,
    input  logic                     rst,
    siren_tone_generator_if.slave    bus
);

    localparam int HALF_MAX = (HI_HALF > LO_HALF) ? HI_HALF : LO_HALF;
    localparam int HW       = $clog2(HALF_MAX);
    localparam int SW       = $clog2(SWAP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HI    = 2'd1,
        LO    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   half_cnt_q, half_cnt_d;
    logic [SW-1:0]   swap_cnt_q, swap_cnt_d;
    logic            swap_pending_q, swap_pending_d;
    logic            level_q, level_d;           // internal, ungated square wave
    logic            siren_out_q, siren_out_d;
    logic            siren_active_q, siren_active_d;
    logic            tone_hi_q, tone_hi_d;

    logic [HW-1:0]   half_last;
    logic            half_term;
    logic [SW-1:0]   swap_next;

    // tone_hi_q tracks the running tone in HI, LO and DRAIN alike, so it
    // selects the half-period length everywhere the counter runs.
    assign half_last = tone_hi_q ? HW'(HI_HALF - 1) : HW'(LO_HALF - 1);
    assign half_term = (half_cnt_q == half_last);
    assign swap_next = (swap_cnt_q == SW'(SWAP - 1)) ? '0 : swap_cnt_q + SW'(1);

    always_comb begin
        state_d        = state_q;
        half_cnt_d     = half_cnt_q;
        swap_cnt_d     = swap_cnt_q;
        swap_pending_d = swap_pending_q;
        level_d        = level_q;
        tone_hi_d      = tone_hi_q;

        case (state_q)
            IDLE: begin
                if (bus.siren_en) begin
                    state_d        = HI;
                    level_d        = 1'b1;
                    half_cnt_d     = '0;
                    swap_cnt_d     = '0;
                    swap_pending_d = 1'b0;
                    tone_hi_d      = 1'b1;
                end
            end

            HI, LO, DRAIN: begin
                // A request drop ends at once when low, and a high level that
                // is timing out on this very edge ends too; otherwise the
                // high level runs to completion through DRAIN.
                if (!bus.siren_en && (!level_q || half_term)) begin
                    state_d        = IDLE;
                    level_d        = 1'b0;
                    half_cnt_d     = '0;
                    swap_cnt_d     = '0;
                    swap_pending_d = 1'b0;
                    tone_hi_d      = 1'b0;
                end else begin
                    swap_cnt_d = swap_next;

                    if (half_term) begin
                        level_d    = ~level_q;
                        half_cnt_d = '0;
                        // Swaps are only honoured while actively toning; a
                        // pending swap is held across DRAIN.
                        if (swap_pending_q && (state_q != DRAIN)) begin
                            tone_hi_d      = ~tone_hi_q;
                            state_d        = tone_hi_q ? LO : HI;
                            swap_pending_d = 1'b0;
                        end
                    end else begin
                        half_cnt_d = half_cnt_q + HW'(1);
                    end

                    // Pending is raised on the edge the swap counter reaches
                    // its last value, so a coincident half terminal still
                    // toggles at the old length.
                    if (swap_next == SW'(SWAP - 1)) begin
                        swap_pending_d = 1'b1;
                    end

                    if (!bus.siren_en) begin
                        state_d = DRAIN;
                    end else if (state_q == DRAIN) begin
                        state_d = tone_hi_q ? HI : LO;
                    end
                end
            end

            default: begin
                state_d        = IDLE;
                level_d        = 1'b0;
                half_cnt_d     = '0;
                swap_cnt_d     = '0;
                swap_pending_d = 1'b0;
                tone_hi_d      = 1'b0;
            end
        endcase

        siren_active_d = (state_d != IDLE);
`ifdef SIREN_MUTE_EN
        siren_out_d    = level_d & ~bus.mute;
`else
        siren_out_d    = level_d;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            half_cnt_q     <= '0;
            swap_cnt_q     <= '0;
            swap_pending_q <= 1'b0;
            level_q        <= 1'b0;
            siren_out_q    <= 1'b0;
            siren_active_q <= 1'b0;
            tone_hi_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            half_cnt_q     <= half_cnt_d;
            swap_cnt_q     <= swap_cnt_d;
            swap_pending_q <= swap_pending_d;
            level_q        <= level_d;
            siren_out_q    <= siren_out_d;
            siren_active_q <= siren_active_d;
            tone_hi_q      <= tone_hi_d;
        end
    end

    assign bus.siren_out    = siren_out_q;
    assign bus.siren_active = siren_active_q;
    assign bus.tone_hi      = tone_hi_q;

endmodule

// File: tb/tb_siren_tone_generator.sv
// tb/tb_siren_tone_generator.sv - directed bench for siren_tone_generator
module tb_siren_tone_generator;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    siren_tone_generator_if bus ();

    siren_tone_generator #(
        .HI_HALF (4),
        .LO_HALF (6),
        .SWAP    (40)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        int   edge_n;
        logic out;
        logic active;
        logic tone;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", name, got, exp);
        end
    endtask

    task automatic chk3(input string name, input logic o, input logic a, input logic t);
        chk({name, ".out"},    bus.siren_out,    o);
        chk({name, ".active"}, bus.siren_active, a);
        chk({name, ".tone"},   bus.tone_hi,      t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then raise siren_en; returns just after edge 0.
    task automatic start_run();
        rst = 1'b0;
        bus.siren_en = 1'b0;
`ifdef SIREN_MUTE_EN
        bus.mute = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk3("reset", 1'b0, 1'b0, 1'b0);
        bus.siren_en = 1'b1;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.siren_en = 1'b0;
`ifdef SIREN_MUTE_EN
        bus.mute = 1'b0;
`endif

        // Continuous run: 4/4 high tone, swap to 6/6 at edge 40, back at 82.
        vecs[0]  = '{0,  1'b1, 1'b1, 1'b1};
        vecs[1]  = '{3,  1'b1, 1'b1, 1'b1};
        vecs[2]  = '{4,  1'b0, 1'b1, 1'b1};
        vecs[3]  = '{8,  1'b1, 1'b1, 1'b1};
        vecs[4]  = '{39, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{40, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{45, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{46, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{51, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{52, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{79, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{81, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{82, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{85, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{86, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{89, 1'b1, 1'b1, 1'b1};

        start_run();
        begin
            int idx;
            idx = 0;
            for (int k = 0; k <= 89; k++) begin
                if (k > 0) tick();
                if (idx < 16 && vecs[idx].edge_n == k) begin
                    chk3($sformatf("run.e%0d", k), vecs[idx].out, vecs[idx].active, vecs[idx].tone);
                    idx++;
                end
            end
        end

        // Drop while high with half counter at 1: drains two edges.
        start_run();
        tick();                 // edge 1
        bus.siren_en = 1'b0;
        tick();                 // edge 2
        chk3("drain.e2", 1'b1, 1'b1, 1'b1);
        tick();                 // edge 3
        chk3("drain.e3", 1'b1, 1'b1, 1'b1);
        tick();                 // edge 4
        chk3("drain.e4", 1'b0, 1'b0, 1'b0);
        for (int k = 5; k <= 10; k++) tick();
        chk3("drain.quiet", 1'b0, 1'b0, 1'b0);

        // Drop while low: idle on that edge.
        start_run();
        for (int k = 1; k <= 4; k++) tick();
        chk3("low.e4", 1'b0, 1'b1, 1'b1);
        bus.siren_en = 1'b0;
        tick();                 // edge 5
        chk3("low.e5", 1'b0, 1'b0, 1'b0);
        for (int k = 6; k <= 10; k++) tick();
        chk3("low.quiet", 1'b0, 1'b0, 1'b0);

        // Reassert during DRAIN: waveform continues undisturbed.
        start_run();
        tick();                 // edge 1
        bus.siren_en = 1'b0;
        tick();                 // edge 2 -> DRAIN
        bus.siren_en = 1'b1;
        tick();                 // edge 3
        chk3("resume.e3", 1'b1, 1'b1, 1'b1);
        tick();                 // edge 4
        chk3("resume.e4", 1'b0, 1'b1, 1'b1);
        for (int k = 5; k <= 8; k++) tick();
        chk3("resume.e8", 1'b1, 1'b1, 1'b1);

        // Asynchronous reset mid-high-level.
        start_run();
        tick();                 // edge 1
        #5;
        rst = 1'b0;
        #1;
        chk3("async_rst", 1'b0, 1'b0, 1'b0);
        #10;
        rst = 1'b1;
        tick();
        chk3("restart.e0", 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) tick();
        chk3("restart.e4", 1'b0, 1'b1, 1'b1);

`ifdef SIREN_MUTE_EN
        // Mute gates the output only; release mid-level restores the phase.
        start_run();
        bus.mute = 1'b1;
        tick();                 // edge 1
        chk3("mute.e1", 1'b0, 1'b1, 1'b1);
        bus.mute = 1'b0;
        tick();                 // edge 2
        chk3("mute.e2", 1'b1, 1'b1, 1'b1);
        tick();                 // edge 3
        chk3("mute.e3", 1'b1, 1'b1, 1'b1);
        tick();                 // edge 4
        chk3("mute.e4", 1'b0, 1'b1, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
